divider: RTL and testbench
==========================

Name: divider

Overview:
- Multi-cycle 32-bit integer divider producing quotient and remainder. Each operand can be treated as signed or unsigned, selected independently.
- Sits beside the core's execute stage as a shared arithmetic IP.
- Uses an iterative radix-2 restoring algorithm on operand magnitudes, followed by sign correction.
- Result is flagged with a one-cycle data_valid pulse.

Parameters:
- None. Datapath width is fixed at 32 bits.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- input_a  input  32  dividend
- input_b  input  32  divisor
- signed_a  input  1  1 = input_a is two's-complement signed
- signed_b  input  1  1 = input_b is two's-complement signed
- enable  input  1  start request; sampled only in IDLE
- output_quotient  output  32  registered quotient
- output_remainder  output  32  registered remainder
- data_valid  output  1  high for exactly one cycle when outputs update

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-division):
  - state -> IDLE, iteration counter -> 0.
  - output_quotient, output_remainder and data_valid -> 0.
  - Any in-flight operation is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If enable=1 at edge T, capture input_a, input_b, signed_a and signed_b; go to BUSY with counter=0.
  - Otherwise stay in IDLE.
- Operand handling at capture:
  - neg_a = signed_a & input_a[31]; neg_b = signed_b & input_b[31].
  - Magnitudes |a| and |b| are computed as 32-bit unsigned values. The magnitude of 0x80000000 is 2^31.
- BUSY:
  - One restoring step per cycle, MSB first: shift the partial remainder left and bring in the next dividend bit.
  - If the partial remainder is >= |b|, subtract |b| and set the quotient bit to 1; otherwise set it to 0.
  - Use a 33-bit partial remainder.
  - 32 iterations, at edges T+1 .. T+32. At edge T+32, go to DONE and load the output registers.
- Sign correction, applied when loading outputs:
  - quotient = (neg_a ^ neg_b) ? -q_mag : q_mag
  - remainder = neg_a ? -r_mag : r_mag
  - Division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (captured input_b == 0):
  - output_quotient = 0xFFFFFFFF and output_remainder = captured input_a, regardless of signed flags.
  - Same latency as a normal division.
- Signed overflow (neg_a, input_a=0x80000000, signed_b=1, input_b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- DONE:
  - data_valid = 1 for this single cycle (the cycle following edge T+32).
  - Unconditionally go to IDLE at the next edge.
- Latency: enable sampled at edge T -> data_valid high between edges T+32 and T+33.
- Back-to-back: if enable is held high continuously, a new capture occurs at edge T+34, one IDLE cycle after DONE. The next data_valid is therefore 34 cycles after the previous one.
- Outputs hold their last values outside DONE and change only on entry to DONE or on reset.
- Input changes during BUSY or DONE are ignored.
- enable during BUSY or DONE is ignored; there is no queueing.

Test Plan:
- Unsigned basic: input_a=15634654, input_b=21354, signed flags=0, enable held 1 -> data_valid one cycle, 32 cycles after the capture edge; quotient=732, remainder=3526.
- Signed: input_a=-100 (0xFFFFFF9C), input_b=7, signed_a=signed_b=1 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2).
- Mixed and unsigned large: input_a=0x80000000, input_b=0xFFFFFFFF, both unsigned -> quotient=0, remainder=0x80000000. Same operands with both signed -> quotient=0x80000000, remainder=0.
- Divide by zero: input_a=5, input_b=0 -> quotient=0xFFFFFFFF, remainder=5. Signed input_a=-5 -> remainder=0xFFFFFFFB.
- Reset mid-op: assert reset at cycle 10 of BUSY -> next cycle state IDLE, outputs 0, no data_valid. After release with enable=1, a fresh division completes with correct results.
- Continuous enable with operands changed during BUSY -> the result reflects the captured operands, and the data_valid pulses are spaced 34 cycles apart.

Source files
------------

// File: rtl/divider.sv
// Multi-cycle 32-bit integer divider: radix-2 restoring iteration on operand
// magnitudes, one quotient bit per cycle, sign correction when results are loaded.
module divider (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        signed_a,
    input  logic        signed_b,
    input  logic        enable,
    output logic [31:0] output_quotient,
    output logic [31:0] output_remainder,
    output logic        data_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [4:0]  count_reg;
    logic [31:0] dividend_reg;
    logic [31:0] divisor_reg;
    logic [31:0] quotient_reg;
    logic [32:0] partial_reg;
    logic [31:0] raw_a_reg;
    logic        neg_a_reg;
    logic        neg_b_reg;
    logic        div_zero_reg;

    // Capture-time operand decode
    logic        neg_a_next;
    logic        neg_b_next;
    logic [31:0] mag_a_next;
    logic [31:0] mag_b_next;

    assign neg_a_next = signed_a & input_a[31];
    assign neg_b_next = signed_b & input_b[31];
    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    assign mag_a_next = neg_a_next ? (~input_a + 32'd1) : input_a;
    assign mag_b_next = neg_b_next ? (~input_b + 32'd1) : input_b;

    // One restoring step
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [32:0] partial_next;
    logic [31:0] quotient_next;

    assign shifted       = {partial_reg[31:0], dividend_reg[31]};
    assign diff          = shifted - {1'b0, divisor_reg};
    assign fits          = (shifted >= {1'b0, divisor_reg});
    assign partial_next  = fits ? diff : shifted;
    assign quotient_next = {quotient_reg[30:0], fits};

    // Final result selection, used only on the last step
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_final;
    logic [31:0] r_final;

    assign q_mag = quotient_next;
    assign r_mag = partial_next[31:0];

    always_comb begin
        q_final = q_mag;
        r_final = r_mag;
        if (div_zero_reg) begin
            q_final = 32'hFFFF_FFFF;
            r_final = raw_a_reg;
        end else begin
            if (neg_a_reg ^ neg_b_reg)
                q_final = ~q_mag + 32'd1;
            if (neg_a_reg)
                r_final = ~r_mag + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            count_reg        <= 5'd0;
            dividend_reg     <= 32'd0;
            divisor_reg      <= 32'd0;
            quotient_reg     <= 32'd0;
            partial_reg      <= 33'd0;
            raw_a_reg        <= 32'd0;
            neg_a_reg        <= 1'b0;
            neg_b_reg        <= 1'b0;
            div_zero_reg     <= 1'b0;
            output_quotient  <= 32'd0;
            output_remainder <= 32'd0;
            data_valid       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    data_valid <= 1'b0;
                    if (enable) begin
                        state_reg    <= BUSY;
                        count_reg    <= 5'd0;
                        dividend_reg <= mag_a_next;
                        divisor_reg  <= mag_b_next;
                        quotient_reg <= 32'd0;
                        partial_reg  <= 33'd0;
                        raw_a_reg    <= input_a;
                        neg_a_reg    <= neg_a_next;
                        neg_b_reg    <= neg_b_next;
                        div_zero_reg <= (input_b == 32'd0);
                    end
                end
                BUSY: begin
                    dividend_reg <= {dividend_reg[30:0], 1'b0};
                    partial_reg  <= partial_next;
                    quotient_reg <= quotient_next;
                    count_reg    <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        state_reg        <= DONE;
                        output_quotient  <= q_final;
                        output_remainder <= r_final;
                        data_valid       <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg  <= IDLE;
                    count_reg  <= 5'd0;
                    data_valid <= 1'b0;
                end
                default: begin
                    state_reg  <= IDLE;
                    count_reg  <= 5'd0;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Bench for divider: directed corner cases plus random operands, compared
// against a plain-arithmetic reference model.
module tb_divider;

    logic        clock;
    logic        reset;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        signed_a;
    logic        signed_b;
    logic        enable;
    logic [31:0] output_quotient;
    logic [31:0] output_remainder;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    divider dut (
        .clock            (clock),
        .reset            (reset),
        .input_a          (input_a),
        .input_b          (input_b),
        .signed_a         (signed_a),
        .signed_b         (signed_b),
        .enable           (enable),
        .output_quotient  (output_quotient),
        .output_remainder (output_remainder),
        .data_valid       (data_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truncating division on 64-bit integers; remainder follows dividend sign
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic sa, input logic sb,
                                    output logic [31:0] q, output logic [31:0] r);
        longint av;
        longint bv;
        longint qq;
        longint rr;
        av = sa ? longint'($signed(a)) : longint'(a);
        bv = sb ? longint'($signed(b)) : longint'(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            qq = av / bv;
            rr = av % bv;
            q  = qq[31:0];
            r  = rr[31:0];
        end
    endfunction

    // Waits for data_valid after a capture edge; returns edges elapsed (0 on timeout)
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input string tag);
        logic [31:0] eq, er;
        int lat;
        ref_div(a, b, sa, sb, eq, er);
        @(negedge clock);
        input_a  = a;
        input_b  = b;
        signed_a = sa;
        signed_b = sb;
        enable   = 1'b1;
        @(posedge clock);
        #1;
        enable  = 1'b0;
        input_a = $urandom;
        input_b = $urandom;
        wait_valid(lat);
        check({tag, "_latency"}, lat, 32);
        check({tag, "_quot"}, output_quotient, eq);
        check({tag, "_rem"}, output_remainder, er);
        @(posedge clock);
        #1;
        check({tag, "_pulse_end"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_hold_quot"}, output_quotient, eq);
        $display("op %s: a=%h b=%h sa=%0d sb=%0d -> q=%h r=%h latency=%0d",
                 tag, a, b, sa, sb, output_quotient, output_remainder, lat);
    endtask

    initial begin
        logic [31:0] eq, er, ra, rb;
        int lat;
        reset    = 1'b1;
        enable   = 1'b0;
        input_a  = 32'd0;
        input_b  = 32'd0;
        signed_a = 1'b0;
        signed_b = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_quot", output_quotient, 32'd0);
        check("reset_rem", output_remainder, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases
        run_op(32'd15634654, 32'd21354, 1'b0, 1'b0, "unsigned_basic");
        check("unsigned_basic_const_q", output_quotient, 32'd732);
        check("unsigned_basic_const_r", output_remainder, 32'd3526);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, "signed_neg100_7");
        check("signed_const_q", output_quotient, 32'hFFFF_FFF2);
        check("signed_const_r", output_remainder, 32'hFFFF_FFFE);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "unsigned_large");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, "signed_overflow");
        check("overflow_const_q", output_quotient, 32'h8000_0000);
        run_op(32'd5, 32'd0, 1'b0, 1'b0, "divzero_pos");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, "divzero_neg");
        check("divzero_neg_const_r", output_remainder, 32'hFFFF_FFFB);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, "mixed_ua_sb");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "mixed_sa_ub");
        run_op(32'd12345, 32'd1, 1'b1, 1'b1, "div_by_one");

        // Reset during BUSY discards the operation
        @(negedge clock);
        input_a  = 32'd1000;
        input_b  = 32'd3;
        signed_a = 1'b0;
        signed_b = 1'b0;
        enable   = 1'b1;
        @(posedge clock);
        #1;
        enable = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset_quot", output_quotient, 32'd0);
        check("midreset_rem", output_remainder, 32'd0);
        check("midreset_valid", {31'd0, data_valid}, 32'd0);
        reset = 1'b0;
        wait_valid(lat);
        check("midreset_no_pulse", lat, 0);
        run_op(32'd1000, 32'd3, 1'b0, 1'b0, "after_reset");

        // Continuous enable; operands change while busy
        @(negedge clock);
        input_a  = 32'd999;
        input_b  = 32'd10;
        signed_a = 1'b0;
        signed_b = 1'b0;
        enable   = 1'b1;
        @(posedge clock);
        #1;
        input_a  = 32'hFFFF_FC18;
        input_b  = 32'd33;
        signed_a = 1'b1;
        signed_b = 1'b0;
        wait_valid(lat);
        check("b2b_first_latency", lat, 32);
        check("b2b_first_quot", output_quotient, 32'd99);
        check("b2b_first_rem", output_remainder, 32'd9);
        $display("b2b first: q=%h r=%h latency=%0d", output_quotient, output_remainder, lat);
        ref_div(32'hFFFF_FC18, 32'd33, 1'b1, 1'b0, eq, er);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (k == 2) begin
                input_a = 32'd77;
                input_b = 32'd5;
            end
            if (data_valid === 1'b1) begin
                lat = k;
                break;
            end
            lat = 0;
        end
        enable = 1'b0;
        check("b2b_spacing", lat, 34);
        check("b2b_second_quot", output_quotient, eq);
        check("b2b_second_rem", output_remainder, er);
        $display("b2b second: q=%h r=%h spacing=%0d", output_quotient, output_remainder, lat);
        @(posedge clock);
        #1;

        // Random operands, with occasional corner values
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
